// File: rtl/seg_scan_decoder.sv
// Monitor for a multiplexed seven-segment display: rebuilds the four shown
// characters from the an/seg lines and flags frame changes, scroll steps and lost scanning.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [11:0] frame,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        scroll_left,
    output logic [7:0]  scroll_count,
    output logic        signal_lost
);

    localparam logic [7:0]  STABLE_MAX   = 8'(STABLE_CYCLES);
    localparam logic [23:0] TIMEOUT_MAX  = 24'(TIMEOUT_CYCLES);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

    function automatic logic [2:0] decode_glyph(input logic [6:0] glyph);
        case (glyph)
            7'h7F:   decode_glyph = 3'd0;
            7'h46:   decode_glyph = 3'd1;
            7'h40:   decode_glyph = 3'd2;
            7'h47:   decode_glyph = 3'd3;
            7'h08:   decode_glyph = 3'd4;
            7'h3F:   decode_glyph = 3'd5;
            default: decode_glyph = 3'd7;
        endcase
    endfunction

    logic [3:0]  an_q, an_prev_q;
    logic [6:0]  seg_q, seg_prev_q;
    logic [7:0]  stab_q, stab_d;
    logic        visit_q, visit_d;
    logic [3:0]  mask_q, mask_d;
    logic [11:0] work_q, work_d;
    logic [23:0] idle_q, idle_d;
    logic        lost_q, lost_d;
    logic [11:0] frame_q, frame_d;
    logic        prev_valid_q, prev_valid_d;
    logic        valid_q, changed_q, scroll_q;
    logic        valid_d, changed_d, scroll_d;
    logic [7:0]  count_q, count_d;

    logic        anode_ok, visit_base, capture, expire, publish, differs, shifted;
    logic [1:0]  slot;

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        anode_ok = 1'b1;
        slot     = 2'd0;
        case (an_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: anode_ok = 1'b0;
        endcase

        stab_d     = stab_q;
        visit_base = visit_q;
        if (!anode_ok) begin
            stab_d     = 8'd0;
            visit_base = 1'b0;
        end else if ({an_q, seg_q} != {an_prev_q, seg_prev_q}) begin
            stab_d     = 8'd1;
            visit_base = 1'b0;
        end else if (stab_q < STABLE_MAX) begin
            stab_d = stab_q + 8'd1;
        end

        capture = anode_ok && (stab_d == STABLE_MAX) && !visit_base;
        visit_d = visit_base || capture;
        expire  = !capture && (idle_q == TIMEOUT_LAST);
        publish = (mask_q == 4'hF);

        idle_d = idle_q;
        if (capture)
            idle_d = 24'd0;
        else if (idle_q != TIMEOUT_MAX)
            idle_d = idle_q + 24'd1;

        lost_d = capture ? 1'b0 : (expire ? 1'b1 : lost_q);

        // A lost scan throws away the partial frame; the published one is kept.
        mask_d = (publish || expire) ? 4'h0 : mask_q;
        work_d = expire ? 12'hFFF : work_q;
        for (int i = 0; i < 4; i++) begin
            if (capture && slot == 2'(i)) begin
                mask_d[i]         = 1'b1;
                work_d[i*3 +: 3] = decode_glyph(seg_q);
            end
        end

        differs      = prev_valid_q && (work_q != frame_q);
        shifted      = differs && (work_q[11:3] == frame_q[8:0]);
        valid_d      = publish;
        changed_d    = publish && differs;
        scroll_d     = publish && shifted;
        frame_d      = publish ? work_q : frame_q;
        prev_valid_d = prev_valid_q || publish;
        count_d      = (publish && shifted) ? count_q + 8'd1 : count_q;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            an_prev_q    <= 4'hF;
            seg_prev_q   <= 7'h7F;
            stab_q       <= 8'd0;
            visit_q      <= 1'b0;
            mask_q       <= 4'h0;
            work_q       <= 12'hFFF;
            idle_q       <= 24'd0;
            lost_q       <= 1'b0;
            frame_q      <= 12'hFFF;
            prev_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
            scroll_q     <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            an_q         <= an;
            seg_q        <= seg;
            an_prev_q    <= an_q;
            seg_prev_q   <= seg_q;
            stab_q       <= stab_d;
            visit_q      <= visit_d;
            mask_q       <= mask_d;
            work_q       <= work_d;
            idle_q       <= idle_d;
            lost_q       <= lost_d;
            frame_q      <= frame_d;
            prev_valid_q <= prev_valid_d;
            valid_q      <= valid_d;
            changed_q    <= changed_d;
            scroll_q     <= scroll_d;
            count_q      <= count_d;
        end
    end

    assign frame         = frame_q;
    assign frame_valid   = valid_q;
    assign frame_changed = changed_q;
    assign scroll_left   = scroll_q;
    assign scroll_count  = count_q;
    assign signal_lost   = lost_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiver-side counterpart of the multiplexed seven-segment driver: watches the an/seg lines and rebuilds the four displayed characters as codes.
- Detects frame changes and one-position right-to-left scroll steps, and flags loss of scan activity.
- Sits beside the display driver, in the same clk domain, as a self-check/monitor block for the scrolling-text designs.

Parameters:
- STABLE_CYCLES, 4, consecutive identical clocks on {an,seg} required before a digit is captured (range 1..255).
- TIMEOUT_CYCLES, 1000000, clocks without a capture before signal_lost asserts (range 2..2^24-1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- an  input  4  anode lines, active-low; an[3] = leftmost digit.
- seg  input  7  segment lines, active-low, {g,f,e,d,c,b,a}.
- frame  output  12  four 3-bit char codes; [11:9] = leftmost (an[3]) ... [2:0] = rightmost (an[0]).
- frame_valid  output  1  one-cycle pulse when frame updates.
- frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous one.
- scroll_left  output  1  one-cycle pulse, coincident with frame_valid, when the new frame is the previous one shifted one digit left.
- scroll_count  output  8  count of scroll_left pulses; wraps 255 -> 0.
- signal_lost  output  1  level; high while there has been no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset values:
  - frame = 12'hFFF (all unknown).
  - frame_valid, frame_changed, scroll_left, scroll_count = 0.
  - signal_lost = 0.
  - Internal state: capture mask = 0, stability counter = 0, visit flag = 0, timeout counter = 0, previous-frame-valid flag = 0.
- Input stage: {an,seg} registered once (1 clk). All logic below uses the registered values.
- Valid anode: exactly one bit of an low. Any other pattern clears the stability counter and visit flag, and produces no capture.
- Stability:
  - Counter increments (saturating at STABLE_CYCLES) while registered {an,seg} equals the previous registered value and the anode is valid.
  - Any change reloads the counter to 1 and clears the visit flag.
- Capture: when the counter reaches STABLE_CYCLES and the visit flag is 0:
  - Decode seg, write the code into that digit's slot of the working frame.
  - Set the digit's mask bit and set the visit flag, so there is only one capture per visit.
  - Clear the timeout counter.
- Decode (seg -> code):
  - 7F -> 0 (blank)
  - 46 -> 1 (C)
  - 40 -> 2 (O)
  - 47 -> 3 (L)
  - 08 -> 4 (A)
  - 3F -> 5 (-)
  - anything else -> 7 (unknown)
  - Code 6 is unused.
- Frame publish: on the cycle after a capture makes mask == 4'hF:
  - frame <= working frame; frame_valid = 1 for one cycle; mask cleared.
  - Same-cycle comparison against the previously published frame. Skip the comparison if there was no previous frame since reset; frame_changed and scroll_left are then 0.
  - frame_changed = (new != prev).
  - scroll_left = (new[11:3] == prev[8:0]) && frame_changed.
  - scroll_count increments in the same cycle scroll_left is high.
- Recapture of an already-captured digit before the mask completes: overwrites that slot. The mask bit stays set and there is no extra publish.
- Timeout: the counter increments every clk without a capture.
  - When it reaches TIMEOUT_CYCLES: signal_lost = 1, mask cleared, working frame set to 12'hFFF. The published frame holds its value.
  - The first subsequent capture clears signal_lost in the same cycle as the capture register update.
  - The first frame after recovery publishes normally; comparison is against the last published frame.
- Simultaneous capture and timeout expiry in the same cycle: capture wins, and signal_lost stays or goes 0.
- Reset mid-frame: all state returns to reset values on the next edge. The partial frame is discarded.

Test Plan:
- Reset with an=4'hF held -> frame=12'hFFF, all pulses 0; signal_lost rises exactly TIMEOUT_CYCLES clocks after reset deassert (use TIMEOUT_CYCLES=50).
- Scan "COCA" (an 7,B,D,E with seg 46,40,46,08), each held 8 clks, STABLE_CYCLES=4 -> frame_valid one cycle after the an=E capture; frame=12'b001_010_001_100; frame_changed=0 and scroll_left=0 (first frame).
- Scan "COCA", then "OCA-" -> second publish has frame_changed=1, scroll_left=1, scroll_count=1. Scan "OCA-" again -> frame_valid=1, frame_changed=0, scroll_left=0.
- Each digit held only 3 clks with STABLE_CYCLES=4 -> no captures, no frame_valid. Two anodes low (an=4'h3) for 10 clks -> no capture.
- Glyph seg=7'h00 (all lit) on one digit -> that slot decodes to 3'b111. Drive 256 consecutive scroll steps -> scroll_count wraps to 0.
- Assert reset after 2 of 4 digits captured, then resume the scan -> first frame_valid occurs only after all four digits are recaptured; frame_changed=0 on that publish.
